// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared definitions for the I2C/SCCB write target.
//   - state_e      : receive/transmit FSM states
//   - ACK / NACK   : SDA levels for the acknowledge slot
//   - BYTE_W       : bits per I2C byte
//   - REG_AW       : register address width (two address bytes)
package i2c_tgt_pkg;

  localparam int BYTE_W = 8;
  localparam int REG_AW = 16;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_A,
    S_REG_HI,
    S_ACK_RH,
    S_REG_LO,
    S_ACK_RL,
    S_DATA,
    S_ACK_D,
    S_TX,
    S_RX_ACK,
    S_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings raw SCL/SDA into the ack_clk domain and decodes
// bus events.
//   ack_clk, reset     : clock, asynchronous active-high reset
//   scl_in, sda_in     : raw pin levels
//   scl_rise, scl_fall : single-cycle SCL edge flags
//   start, stop        : single-cycle START / STOP flags
//   sda_s              : synchronised SDA level
// Synchroniser and edge registers reset to 1 (idle bus) so that releasing
// reset on an idle bus never produces a spurious event.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ack_clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_q_reg;
  logic                   sda_q_reg;
  logic                   scl_s;

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_q_reg    <= 1'b1;
      sda_q_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_q_reg    <= scl_s;
      sda_q_reg    <= sda_s;
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_q_reg;
  assign scl_fall = ~scl_s & scl_q_reg;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is not mistaken for START/STOP.
  assign start = scl_s & scl_q_reg & sda_q_reg & ~sda_s;
  assign stop  = scl_s & scl_q_reg & ~sda_q_reg & sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C/SCCB target that accepts
//   START, ADDR/W, REG[15:8], REG[7:0], DATA..., STOP
// and emits one wr_stb per data byte (register address auto-increments).
// Optional read service is compiled in with macro I2C_TGT_READ_EN.
//   ack_clk, reset  : clock (>= 8x SCL), asynchronous active-high reset
//   scl_in, sda_in  : raw bus levels
//   sda_oe          : 1 = pull SDA low
//   wr_addr/wr_data : write register address / data, valid with wr_stb
//   rd_addr/rd_stb  : read request (read build only, else 0)
//   rd_data         : read data, sampled one cycle after rd_stb
//   busy            : addressed transaction in progress
//   nack_seen       : sticky, master NACKed a read byte
module i2c_target_rx
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h78,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                ack_clk,
  input  logic                reset,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [REG_AW-1:0]   wr_addr,
  output logic [BYTE_W-1:0]   wr_data,
  output logic                wr_stb,
  output logic [REG_AW-1:0]   rd_addr,
  input  logic [BYTE_W-1:0]   rd_data,
  output logic                rd_stb,
  output logic                busy,
  output logic                nack_seen
);

`ifdef I2C_TGT_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
  wire unused_rd_data = ^rd_data;
`endif

  // Reset asserts asynchronously (SDA is released at once) but releases on
  // a clock edge.
  logic [1:0] rst_sync_reg;
  logic       rst_int;

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) rst_sync_reg <= 2'b11;
    else       rst_sync_reg <= {rst_sync_reg[0], 1'b0};
  end
  assign rst_int = rst_sync_reg[1];

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .ack_clk  (ack_clk),
    .reset    (rst_int),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det),
    .sda_s    (sda_s)
  );

  state_e              state_reg, state_next;
  logic [BYTE_W-1:0]   shift_reg, shift_next;
  logic [2:0]          bit_cnt_reg, bit_cnt_next;
  logic                sda_oe_reg, sda_oe_next;
  logic [REG_AW-1:0]   wr_addr_reg, wr_addr_next;
  logic [BYTE_W-1:0]   wr_data_reg, wr_data_next;
  logic                wr_stb_reg, wr_stb_next;
  logic                busy_reg, busy_next;
  logic                rw_reg, rw_next;
  logic [REG_AW-1:0]   rd_addr_reg, rd_addr_next;
  logic                rd_stb_reg, rd_stb_next;
  logic                nack_reg, nack_next;
  logic [BYTE_W-1:0]   tx_reg, tx_next;
  logic                tx_wait_reg, tx_wait_next;

  logic [BYTE_W-1:0]   byte_in;
  logic                last_bit;
  logic                rx_state;
  logic                addr_ok;

  // byte_in is the complete byte on the cycle its 8th bit is sampled.
  assign byte_in  = {shift_reg[BYTE_W-2:0], sda_s};
  assign last_bit = scl_rise && (bit_cnt_reg == 3'd7);
  assign rx_state = (state_reg == S_ADDR) || (state_reg == S_REG_HI) ||
                    (state_reg == S_REG_LO) || (state_reg == S_DATA);
  assign addr_ok  = (byte_in[7:1] == ADDR) && (!byte_in[0] || READ_EN);

  // State register
  always_ff @(posedge ack_clk or posedge rst_int) begin
    if (rst_int) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic; START/STOP override every state, even mid-byte.
  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = S_ADDR;
    end else if (stop_det) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_ADDR:   if (last_bit) state_next = addr_ok ? S_ACK_A : S_IGNORE;
        S_ACK_A:  if (scl_fall && sda_oe_reg) state_next = rw_reg ? S_TX : S_REG_HI;
        S_REG_HI: if (last_bit) state_next = S_ACK_RH;
        S_ACK_RH: if (scl_fall && sda_oe_reg) state_next = S_REG_LO;
        S_REG_LO: if (last_bit) state_next = S_ACK_RL;
        S_ACK_RL: if (scl_fall && sda_oe_reg) state_next = S_DATA;
        S_DATA:   if (last_bit) state_next = S_ACK_D;
        S_ACK_D:  if (scl_fall && sda_oe_reg) state_next = S_DATA;
        S_TX:     if (last_bit) state_next = S_RX_ACK;
        S_RX_ACK: if (scl_rise) state_next = (sda_s == ACK) ? S_TX : S_IGNORE;
        default:  state_next = state_reg;
      endcase
    end
  end

  // Output/datapath next-values
  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    sda_oe_next  = sda_oe_reg;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    wr_stb_next  = 1'b0;
    busy_next    = busy_reg;
    rw_next      = rw_reg;
    rd_addr_next = rd_addr_reg;
    rd_stb_next  = 1'b0;
    nack_next    = nack_reg;
    tx_next      = tx_reg;
    tx_wait_next = tx_wait_reg;

`ifdef I2C_TGT_READ_EN
    if (rd_stb_reg) tx_next = rd_data;
`endif

    if (start_det) begin
      // Any partial byte is dropped; latched register addresses survive.
      bit_cnt_next = 3'd0;
      sda_oe_next  = 1'b0;
      nack_next    = 1'b0;
      tx_wait_next = 1'b0;
    end else if (stop_det) begin
      bit_cnt_next = 3'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      if (scl_rise && (rx_state || state_reg == S_TX)) begin
        shift_next   = byte_in;
        bit_cnt_next = bit_cnt_reg + 3'd1;
      end
      case (state_reg)
        S_ADDR: if (last_bit) begin
          if (addr_ok) begin
            busy_next = 1'b1;
            rw_next   = byte_in[0];
`ifdef I2C_TGT_READ_EN
            rd_stb_next = byte_in[0];
`endif
          end else begin
            busy_next = 1'b0;
          end
        end
        S_REG_HI: if (last_bit) wr_addr_next[15:8] = byte_in;
        S_REG_LO: if (last_bit) begin
          wr_addr_next[7:0] = byte_in;
`ifdef I2C_TGT_READ_EN
          rd_addr_next = {wr_addr_reg[15:8], byte_in};
`endif
        end
        S_DATA: if (last_bit) begin
          wr_data_next = byte_in;
          wr_stb_next  = 1'b1;
        end
        // First fall after the byte starts the ACK, second fall ends it;
        // sda_oe itself tells the two falls apart.
        S_ACK_A, S_ACK_RH, S_ACK_RL, S_ACK_D: if (scl_fall) begin
          if (!sda_oe_reg) begin
            sda_oe_next = 1'b1;
          end else begin
            sda_oe_next = 1'b0;
            if (state_reg == S_ACK_D) wr_addr_next = wr_addr_reg + 16'd1;
`ifdef I2C_TGT_READ_EN
            if (state_reg == S_ACK_A && rw_reg) sda_oe_next = ~tx_reg[7];
`endif
          end
        end
`ifdef I2C_TGT_READ_EN
        // tx_wait: the byte was fetched during the master's ACK clock, so
        // its MSB goes out on the fall that ends that clock.
        S_TX: if (scl_fall) begin
          if (tx_wait_reg) begin
            sda_oe_next  = ~tx_reg[7];
            tx_wait_next = 1'b0;
          end else begin
            tx_next     = {tx_reg[6:0], 1'b0};
            sda_oe_next = ~tx_reg[6];
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
          end else if (scl_rise) begin
            if (sda_s == ACK) begin
              rd_addr_next = rd_addr_reg + 16'd1;
              rd_stb_next  = 1'b1;
              tx_wait_next = 1'b1;
            end else begin
              nack_next = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge ack_clk or posedge rst_int) begin
    if (rst_int) begin
      shift_reg   <= '0;
      bit_cnt_reg <= 3'd0;
      sda_oe_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_stb_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      rw_reg      <= 1'b0;
      rd_addr_reg <= '0;
      rd_stb_reg  <= 1'b0;
      nack_reg    <= 1'b0;
      tx_reg      <= '0;
      tx_wait_reg <= 1'b0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      sda_oe_reg  <= sda_oe_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      wr_stb_reg  <= wr_stb_next;
      busy_reg    <= busy_next;
      rw_reg      <= rw_next;
      rd_addr_reg <= rd_addr_next;
      rd_stb_reg  <= rd_stb_next;
      nack_reg    <= nack_next;
      tx_reg      <= tx_next;
      tx_wait_reg <= tx_wait_next;
    end
  end

  // Outputs
  always_comb begin
    sda_oe    = sda_oe_reg;
    wr_addr   = wr_addr_reg;
    wr_data   = wr_data_reg;
    wr_stb    = wr_stb_reg;
    rd_addr   = rd_addr_reg;
    rd_stb    = rd_stb_reg;
    busy      = busy_reg;
    nack_seen = nack_reg;
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, open-drain SDA model,
// queue-based write/read reference model, randomized write transactions.
module tb_i2c_target_rx;

  localparam logic [6:0] TGT = 7'h78;
  localparam int         Q   = 6;   // quarter SCL period in ack_clk cycles

  logic        ack_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        scl_mst = 1'b1;
  logic        sda_mst = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;
  logic        wr_stb, rd_stb, busy, nack_seen;

  int total = 0;
  int bad   = 0;

  logic [23:0] stb_q[$];
  logic [15:0] rdstb_q[$];
  int          oe_cnt = 0;
  logic [7:0]  wbuf[8];

  always #5 ack_clk = ~ack_clk;

  // Open-drain bus: line low if either side pulls.
  assign sda_in = sda_mst & ~sda_oe;

  // Register file seen by the read path.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (a == 16'h300A)      return 8'h56;
    else if (a == 16'h300B) return 8'h9A;
    else                    return a[7:0] ^ a[15:8];
  endfunction

  assign rd_data = mem_val(rd_addr);

  i2c_target_rx #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
    .ack_clk   (ack_clk),
    .reset     (reset),
    .scl_in    (scl_mst),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_stb    (wr_stb),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_stb    (rd_stb),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  always @(negedge ack_clk) begin
    if (wr_stb) stb_q.push_back({wr_addr, wr_data});
    if (rd_stb) rdstb_q.push_back(rd_addr);
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ack_clk);
  endtask

  task automatic clk_bit(input logic drive, output logic line);
    sda_mst = drive;
    tick(Q);
    scl_mst = 1'b1;
    tick(Q);
    line = sda_in;
    tick(Q);
    scl_mst = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_mst = 1'b1;
    tick(Q);
    scl_mst = 1'b1;
    tick(Q);
    sda_mst = 1'b0;
    tick(Q);
    scl_mst = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_mst = 1'b0;
    tick(Q);
    scl_mst = 1'b1;
    tick(Q);
    sda_mst = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], line);
    clk_bit(1'b1, line);
    acked = (line == 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, line);
      b[i] = line;
    end
    clk_bit(mack ? 1'b0 : 1'b1, line);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_oe"},   sda_oe,    0);
    check({pfx, "_wstb"}, wr_stb,    0);
    check({pfx, "_rstb"}, rd_stb,    0);
    check({pfx, "_busy"}, busy,      0);
    check({pfx, "_nack"}, nack_seen, 0);
    check({pfx, "_wa"},   wr_addr,   0);
    check({pfx, "_wd"},   wr_data,   0);
    check({pfx, "_ra"},   rd_addr,   0);
  endtask

  // One write transaction: address, two register bytes, n data bytes,
  // optional trailing partial byte, STOP. Expected strobes come from the
  // rule "data byte i lands at reg+i (mod 2^16) if the address matched".
  task automatic run_write(input logic [6:0] dev, input logic [15:0] reg_a,
                           input int n, input int part_bits);
    logic        a, line, match;
    int          base, oe0, exp_n;
    logic [15:0] ea;
    match = (dev == TGT);
    base  = stb_q.size();
    oe0   = oe_cnt;
    i2c_start();
    write_byte({dev, 1'b0}, a);
    check("addr_ack", a, match);
    check("busy_addr", busy, match);
    write_byte(reg_a[15:8], a);
    check("reghi_ack", a, match);
    write_byte(reg_a[7:0], a);
    check("reglo_ack", a, match);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      check("data_ack", a, match);
    end
    for (int i = 0; i < part_bits; i++) clk_bit(1'($urandom), line);
    i2c_stop();
    tick(4);
    exp_n = match ? n : 0;
    check("stb_cnt", stb_q.size() - base, exp_n);
    for (int i = 0; i < exp_n && (base + i) < stb_q.size(); i++) begin
      ea = reg_a + 16'(i);
      check("stb", stb_q[base + i], {ea, wbuf[i]});
    end
    check("busy_stop", busy, 0);
    check("oe_idle", sda_oe, 0);
    if (!match) check("oe_never", oe_cnt - oe0, 0);
    $display("txn dev=%h reg=%h n=%0d part=%0d strobes=%0d",
             dev, reg_a, n, part_bits, stb_q.size() - base);
  endtask

  initial begin
    logic        a;
    logic        line;
    logic [7:0]  b;
    logic [7:0]  adr;
    int          rbase;

    tick(10);
    check_reset_vals("rst0");
    reset = 1'b0;
    tick(10);
    check_reset_vals("post0");

    // Basic single write
    wbuf[0] = 8'h82;
    run_write(TGT, 16'h3008, 1, 0);

    // Wrong address: nothing acknowledged, nothing written
    wbuf[0] = 8'h5A;
    run_write(7'h42, 16'h1111, 1, 0);

    // Burst across the 16-bit wrap
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    run_write(TGT, 16'hFFFF, 2, 0);

    // Partial data byte then STOP, followed by a clean write
    run_write(TGT, 16'h1234, 0, 4);
    wbuf[0] = 8'h05;
    run_write(TGT, 16'h3100, 1, 0);

    // Reset while the address ACK is being driven
    i2c_start();
    adr = {TGT, 1'b0};
    for (int i = 7; i >= 0; i--) clk_bit(adr[i], line);
    check("oe_in_ack", sda_oe, 1);
    #2 reset = 1'b1;
    #1 check("oe_async_rst", sda_oe, 0);
    tick(2);
    scl_mst = 1'b1;
    sda_mst = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    check_reset_vals("midrst");
    wbuf[0] = 8'hC3;
    run_write(TGT, 16'h2000, 1, 0);

    // Randomized writes
    for (int t = 0; t < 12; t++) begin
      logic [6:0]  dev;
      logic [15:0] ra;
      int          n;
      dev = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT;
      ra  = 16'($urandom);
      n   = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      run_write(dev, ra, n, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0);
    end

    // Register read: write pointer 0x300A, repeated START, address/R
    rbase = rdstb_q.size();
    i2c_start();
    write_byte({TGT, 1'b0}, a);
    write_byte(8'h30, a);
    write_byte(8'h0A, a);
    i2c_start();
    write_byte({TGT, 1'b1}, a);
`ifdef I2C_TGT_READ_EN
    check("rd_addr_ack", a, 1);
    read_byte(b, 1'b1);
    check("rd_byte0", b, 8'h56);
    read_byte(b, 1'b0);
    check("rd_byte1", b, 8'h9A);
    i2c_stop();
    tick(4);
    check("rd_nack_seen", nack_seen, 1);
    check("rd_stb_cnt", rdstb_q.size() - rbase, 2);
    if (rdstb_q.size() - rbase >= 2) begin
      check("rd_addr0", rdstb_q[rbase], 16'h300A);
      check("rd_addr1", rdstb_q[rbase + 1], 16'h300B);
    end
    check("rd_addr_end", rd_addr, 16'h300B);
`else
    check("rd_addr_nack", a, 0);
    i2c_stop();
    tick(4);
    check("rd_stb_cnt", rdstb_q.size() - rbase, 0);
    check("rd_nack_seen", nack_seen, 0);
    check("rd_addr_tied", rd_addr, 0);
`endif
    check("rd_busy_stop", busy, 0);
    $display("txn read reg=300a acked=%0d", a);

    // A new START clears nack_seen; write path still intact afterwards
    wbuf[0] = 8'h7E;
    run_write(TGT, 16'h0042, 1, 0);
    check("nack_cleared", nack_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
